// File: rtl/cjb_nbit_alu_seq_v_pkg.sv
// Shared encodings for the sequential N-bit ALU.
// Holds the unit and operation codes carried on Func_Sel, the FSM state
// encoding, the bit positions of the {C,N,V,Z} flag vector, and a helper
// that packs the four flags into that vector.
package cjb_nbit_alu_seq_v_pkg;

  // Func_Sel[3:2]: functional unit
  typedef enum logic [1:0] {
    UNIT_ARITH = 2'b00,
    UNIT_LOGIC = 2'b01,
    UNIT_SHIFT = 2'b10,
    UNIT_CONST = 2'b11
  } unit_e;

  // Func_Sel[1:0] inside the arith unit
  localparam logic [1:0] OP_ADD  = 2'b00;  // X + Y
  localparam logic [1:0] OP_ADC  = 2'b01;  // X + Y + cin
  localparam logic [1:0] OP_SUB  = 2'b10;  // X - Y
  localparam logic [1:0] OP_ADK  = 2'b11;  // X + K

  // Func_Sel[1:0] inside the logic unit
  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NOTX = 2'b11;

  // Func_Sel[1:0] inside the shift/rotate unit
  localparam logic [1:0] OP_LSL  = 2'b00;
  localparam logic [1:0] OP_LSR  = 2'b01;
  localparam logic [1:0] OP_ASR  = 2'b10;
  localparam logic [1:0] OP_ROL  = 2'b11;

  // Func_Sel[1:0] inside the const unit
  localparam logic [1:0] OP_ZERO = 2'b00;
  localparam logic [1:0] OP_ONE  = 2'b01;
  localparam logic [1:0] OP_ONES = 2'b10;
  localparam logic [1:0] OP_KEXT = 2'b11;

  // Controller states
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Bit positions inside ALU_CNVZ
  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  // Place the individual flags at their positions in the 4-bit flag vector
  function automatic logic [3:0] pack_cnvz(input logic c, input logic n,
                                           input logic v, input logic z);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_C] = c;
    f[FLAG_N] = n;
    f[FLAG_V] = v;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/cjb_nbit_sr_step_v.sv
// Single-bit shift/rotate step.
// Shifts or rotates din by exactly one position according to op and reports
// the bit that left the word.
//   din  : word to shift
//   op   : OP_LSL / OP_LSR / OP_ASR / OP_ROL
//   dout : shifted word
//   cout : bit shifted or rotated out
module cjb_nbit_sr_step_v
  import cjb_nbit_alu_seq_v_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] din,
  input  logic [1:0]   op,
  output logic [N-1:0] dout,
  output logic         cout
);

  // One-position shift/rotate selected by op
  always_comb begin
    dout = din;
    cout = 1'b0;
    case (op)
      OP_LSL: begin
        dout = {din[N-2:0], 1'b0};
        cout = din[N-1];
      end
      OP_LSR: begin
        dout = {1'b0, din[N-1:1]};
        cout = din[0];
      end
      OP_ASR: begin
        dout = {din[N-1], din[N-1:1]};
        cout = din[0];
      end
      OP_ROL: begin
        dout = {din[N-2:0], din[N-1]};
        cout = din[N-1];
      end
      default: begin
        dout = din;
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/cjb_nbit_alu_seq_v.sv
// Sequential N-bit ALU with a multi-cycle shifter.
// Arith, logic and const operations (and shifts by zero) complete at the
// accepting edge; shifts by A>0 step one bit per cycle for A cycles.
//   Clock, Reset : rising-edge clock, asynchronous active-high reset
//   Start        : operation request, honoured only while idle
//   Func_Sel     : [3:2] unit, [1:0] operation
//   Operand_X/Y  : operands; shift amount is Operand_Y[clog2(N)-1:0]
//   Const_K      : constant, zero-extended to N bits
//   cin          : carry-in for add-with-carry
//   ALU_Result   : registered result
//   ALU_CNVZ     : registered flags {C,N,V,Z}
//   Busy         : multi-cycle shift in progress
//   Done         : one-cycle pulse when result and flags update
module cjb_nbit_alu_seq_v
  import cjb_nbit_alu_seq_v_pkg::*;
#(
  parameter int N   = 8,
  parameter int K_W = 2
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           Start,
  input  logic [3:0]     Func_Sel,
  input  logic [N-1:0]   Operand_X,
  input  logic [N-1:0]   Operand_Y,
  input  logic [K_W-1:0] Const_K,
  input  logic           cin,
  output logic [N-1:0]   ALU_Result,
  output logic [3:0]     ALU_CNVZ,
  output logic           Busy,
  output logic           Done
);

  localparam int A_W = $clog2(N);

  localparam logic [A_W-1:0] CNT_ZERO = {A_W{1'b0}};
  localparam logic [A_W-1:0] CNT_ONE  = {{(A_W-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]   ZERO_N   = {N{1'b0}};
  localparam logic [N-1:0]   ONE_N    = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]   ONES_N   = {N{1'b1}};

  // Registered state
  state_e         state_r;
  logic [N-1:0]   work_r;
  logic [A_W-1:0] cnt_r;
  logic [1:0]     op_r;
  logic [N-1:0]   result_r;
  logic [3:0]     cnvz_r;
  logic           busy_r;
  logic           done_r;

  // Next-state values
  state_e         state_nxt_s;
  logic [N-1:0]   work_nxt_s;
  logic [A_W-1:0] cnt_nxt_s;
  logic [1:0]     op_nxt_s;
  logic [N-1:0]   result_nxt_s;
  logic [3:0]     cnvz_nxt_s;
  logic           busy_nxt_s;
  logic           done_nxt_s;

  // Decoded request
  unit_e          unit_s;
  logic [1:0]     op_s;
  logic [A_W-1:0] amt_s;
  logic [N-1:0]   k_ext_s;

  // Arith path
  logic [N-1:0]   addend_s;
  logic [N:0]     carry_in_s;
  logic [N:0]     sum_s;
  logic           arith_v_s;

  // Single-cycle result mux
  logic [N-1:0]   logic_res_s;
  logic [N-1:0]   const_res_s;
  logic [N-1:0]   imm_res_s;
  logic           imm_c_s;
  logic           imm_v_s;

  // Shift step
  logic [N-1:0]   step_res_s;
  logic           step_c_s;

  // N and Z always follow the result; C and V come from the unit
  function automatic logic [3:0] make_cnvz(input logic c, input logic v,
                                           input logic [N-1:0] r);
    return pack_cnvz(c, r[N-1], v, (r == ZERO_N));
  endfunction

  assign unit_s  = unit_e'(Func_Sel[3:2]);
  assign op_s    = Func_Sel[1:0];
  assign amt_s   = Operand_Y[A_W-1:0];
  assign k_ext_s = N'(Const_K);

  // Adder operands: subtract is X + ~Y + 1, so the carry-out doubles as "no borrow"
  always_comb begin
    addend_s   = Operand_Y;
    carry_in_s = {(N+1){1'b0}};
    case (op_s)
      OP_ADD: begin
        addend_s   = Operand_Y;
        carry_in_s = {(N+1){1'b0}};
      end
      OP_ADC: begin
        addend_s   = Operand_Y;
        carry_in_s = {{N{1'b0}}, cin};
      end
      OP_SUB: begin
        addend_s   = ~Operand_Y;
        carry_in_s = {{N{1'b0}}, 1'b1};
      end
      OP_ADK: begin
        addend_s   = k_ext_s;
        carry_in_s = {(N+1){1'b0}};
      end
      default: begin
        addend_s   = Operand_Y;
        carry_in_s = {(N+1){1'b0}};
      end
    endcase
  end

  assign sum_s = {1'b0, Operand_X} + {1'b0, addend_s} + carry_in_s;

  // Overflow: operands of equal sign producing a result of the other sign
  assign arith_v_s = (Operand_X[N-1] == addend_s[N-1]) && (sum_s[N-1] != Operand_X[N-1]);

  // Bitwise logic operations
  always_comb begin
    logic_res_s = ZERO_N;
    case (op_s)
      OP_AND:  logic_res_s = Operand_X & Operand_Y;
      OP_OR:   logic_res_s = Operand_X | Operand_Y;
      OP_XOR:  logic_res_s = Operand_X ^ Operand_Y;
      OP_NOTX: logic_res_s = ~Operand_X;
      default: logic_res_s = ZERO_N;
    endcase
  end

  // Constant generator
  always_comb begin
    const_res_s = ZERO_N;
    case (op_s)
      OP_ZERO: const_res_s = ZERO_N;
      OP_ONE:  const_res_s = ONE_N;
      OP_ONES: const_res_s = ONES_N;
      OP_KEXT: const_res_s = k_ext_s;
      default: const_res_s = ZERO_N;
    endcase
  end

  // Result and C/V for everything that completes at the accepting edge
  always_comb begin
    imm_res_s = ZERO_N;
    imm_c_s   = 1'b0;
    imm_v_s   = 1'b0;
    case (unit_s)
      UNIT_ARITH: begin
        imm_res_s = sum_s[N-1:0];
        imm_c_s   = sum_s[N];
        imm_v_s   = arith_v_s;
      end
      UNIT_LOGIC: imm_res_s = logic_res_s;
      // Only reached with a zero shift amount: X passes through, C=0
      UNIT_SHIFT: imm_res_s = Operand_X;
      UNIT_CONST: imm_res_s = const_res_s;
      default:    imm_res_s = ZERO_N;
    endcase
  end

  cjb_nbit_sr_step_v #(
    .N (N)
  ) u_sr_step (
    .din  (work_r),
    .op   (op_r),
    .dout (step_res_s),
    .cout (step_c_s)
  );

  // Controller next-state and datapath register updates
  always_comb begin
    state_nxt_s  = state_r;
    work_nxt_s   = work_r;
    cnt_nxt_s    = cnt_r;
    op_nxt_s     = op_r;
    result_nxt_s = result_r;
    cnvz_nxt_s   = cnvz_r;
    busy_nxt_s   = busy_r;
    done_nxt_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (Start) begin
          if ((unit_s == UNIT_SHIFT) && (amt_s != CNT_ZERO)) begin
            // Everything the shift needs is captured now; inputs are free afterwards
            work_nxt_s  = Operand_X;
            op_nxt_s    = op_s;
            cnt_nxt_s   = amt_s;
            busy_nxt_s  = 1'b1;
            state_nxt_s = ST_SHIFT;
          end else begin
            result_nxt_s = imm_res_s;
            cnvz_nxt_s   = make_cnvz(imm_c_s, imm_v_s, imm_res_s);
            done_nxt_s   = 1'b1;
            state_nxt_s  = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        work_nxt_s = step_res_s;
        cnt_nxt_s  = cnt_r - CNT_ONE;
        if (cnt_r == CNT_ONE) begin
          // Final step: the bit leaving now is the last one shifted out
          result_nxt_s = step_res_s;
          cnvz_nxt_s   = make_cnvz(step_c_s, 1'b0, step_res_s);
          busy_nxt_s   = 1'b0;
          done_nxt_s   = 1'b1;
          state_nxt_s  = ST_IDLE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      default: begin
        busy_nxt_s  = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r  <= ST_IDLE;
      work_r   <= ZERO_N;
      cnt_r    <= CNT_ZERO;
      op_r     <= 2'b00;
      result_r <= ZERO_N;
      cnvz_r   <= 4'b0000;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      work_r   <= work_nxt_s;
      cnt_r    <= cnt_nxt_s;
      op_r     <= op_nxt_s;
      result_r <= result_nxt_s;
      cnvz_r   <= cnvz_nxt_s;
      busy_r   <= busy_nxt_s;
      done_r   <= done_nxt_s;
    end
  end

  assign ALU_Result = result_r;
  assign ALU_CNVZ   = cnvz_r;
  assign Busy       = busy_r;
  assign Done       = done_r;

endmodule
